uart_rx_fifo: RTL and testbench

- Receive end of the team's 8N1 UART link. Accepts the serial line driven by the transmitter, validates the start bit and samples each bit at mid-bit.
- Detects framing errors and buffers received bytes in a small FIFO.
- Presents bytes on a valid/ready stream interface, so a core or bus bridge can drain them without losing data between polls.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx_buf.sv | 62 ++++++
 rtl/uart_rx_fifo.sv | 188 ++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and bit-timing helper.
// No logic and no latency. Backpressure does not apply.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    // Tick index at which the start bit is re-checked, nearest the middle of the bit.
    function automatic int mid_tick(input int ticks_per_bit);
        return (ticks_per_bit - 1) / 2;
    endfunction

endpackage

// File: rtl/uart_rx_buf.sv
// uart_rx_buf: generic synchronous circular FIFO with occupancy count and overrun flag.
// Latency: a push is visible on head/empty/count the cycle after it is written.
// Backpressure: a push into a full FIFO is dropped (unless a pop frees a slot that cycle) and flagged on overrun.
module uart_rx_buf #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic [AW:0]      count,
    output logic             overrun
);

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    // A pop on a full FIFO frees the slot the push lands in, so both proceed.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            overrun <= push && !do_push;
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a byte FIFO; define UART_RX_PARITY_EN for an even-parity bit and parity_err.
// Latency: FIFO write one cycle after the stop-bit sample, valid/data_out the cycle after that.
// Backpressure: valid/ready pop; a byte completing into a full FIFO is dropped and pulses overrun.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int TICKS_PER_BIT = 87,
    parameter int FIFO_DEPTH    = 4,
    localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rx,
    output logic [7:0]    data_out,
    output logic          valid,
    input  logic          ready,
    output logic          frame_err,
    output logic          overrun,
`ifdef UART_RX_PARITY_EN
    output logic          parity_err,
`endif
    output logic [CW-1:0] count
);

    localparam int TW = $clog2(TICKS_PER_BIT);
    localparam int BW = $clog2(UART_DATA_BITS);
    localparam logic [TW-1:0] MID_TICK  = TW'(mid_tick(TICKS_PER_BIT));
    localparam logic [TW-1:0] LAST_TICK = TW'(TICKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(UART_DATA_BITS - 1);

    rx_state_t                 state;
    rx_state_t                 state_nxt;
    logic                      rx_meta;
    logic                      rx_s;
    logic                      rx_prev;
    logic [1:0]                warm;
    logic                      armed;
    logic [TW-1:0]             tick;
    logic [BW-1:0]             bit_idx;
    logic [UART_DATA_BITS-1:0] shreg;
    logic                      tick_clr;
    logic                      shift_en;
    logic                      par_en;
    logic                      stop_en;
    logic                      par_ok;
    logic                      push_q;
    logic                      frame_err_q;
    logic                      buf_empty;

    // The synchroniser resets high; edges are only trusted once real line samples
    // have reached rx_prev, so a line held low through reset is not a start bit.
    assign armed = (warm == 2'd3);

    always_comb begin
        state_nxt = state;
        tick_clr  = 1'b0;
        shift_en  = 1'b0;
        par_en    = 1'b0;
        stop_en   = 1'b0;
        case (state)
            IDLE: begin
                if (armed && rx_prev && !rx_s) begin
                    state_nxt = START;
                    tick_clr  = 1'b1;
                end
            end
            START: begin
                if (tick == MID_TICK) begin
                    tick_clr  = 1'b1;
                    state_nxt = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tick == LAST_TICK) begin
                    shift_en = 1'b1;
                    tick_clr = 1'b1;
                    if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick == LAST_TICK) begin
                    par_en    = 1'b1;
                    tick_clr  = 1'b1;
                    state_nxt = STOP;
                end
            end
`endif
            STOP: begin
                // Leaving mid-stop-bit leaves half a bit to catch a back-to-back start edge.
                if (tick == LAST_TICK) begin
                    stop_en   = 1'b1;
                    tick_clr  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                tick_clr  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta     <= 1'b1;
            rx_s        <= 1'b1;
            rx_prev     <= 1'b1;
            warm        <= 2'd0;
            state       <= IDLE;
            tick        <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            push_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
            if (!armed) begin
                warm <= warm + 2'd1;
            end
            state <= state_nxt;
            if (tick_clr) begin
                tick <= '0;
            end else if (state != IDLE) begin
                tick <= tick + 1'b1;
            end
            if (shift_en) begin
                shreg   <= {rx_s, shreg[UART_DATA_BITS-1:1]};
                bit_idx <= bit_idx + 1'b1;
            end else if (state != DATA) begin
                bit_idx <= '0;
            end
            push_q      <= stop_en && rx_s && par_ok;
            frame_err_q <= stop_en && !rx_s;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_bit;
    logic parity_err_q;

    assign par_ok     = ~^{shreg, par_bit};
    assign parity_err = parity_err_q;

    // A framing error outranks a parity mismatch, so only a good stop bit can raise parity_err.
    always_ff @(posedge clk) begin
        if (reset) begin
            par_bit      <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            if (par_en) begin
                par_bit <= rx_s;
            end
            parity_err_q <= stop_en && rx_s && !par_ok;
        end
    end
`else
    assign par_ok = 1'b1;
`endif

    // shreg holds still in IDLE long past the write, so it feeds the FIFO directly.
    uart_rx_buf #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_BITS)
    ) u_buf (
        .clk      (clk),
        .reset    (reset),
        .push     (push_q),
        .push_dat (shreg),
        .pop      (ready),
        .head     (data_out),
        .empty    (buf_empty),
        .count    (count),
        .overrun  (overrun)
    );

    assign valid     = !buf_empty;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: frame vector table, hand-written corner sequences,
// and a randomized run compared against a queue model of accepted bytes.
module tb_uart_rx_fifo;

    localparam int T     = 87;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;
`ifdef UART_RX_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif
    // Start drive -> valid seen: 2 sync flops + edge detect, start re-check at the mid tick,
    // data/parity/stop bits of T ticks each, then the FIFO write cycle.
    localparam int LAT = 3 + ((T - 1) / 2 + 1) + (8 + PBITS + 1) * T + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          rx;
    logic [7:0]    data_out;
    logic          valid;
    logic          ready;
    logic          frame_err;
    logic          overrun;
    logic [CW-1:0] count;
`ifdef UART_RX_PARITY_EN
    logic          parity_err;
`endif

    logic ready_man = 1'b0;
    logic rand_en   = 1'b0;
    logic rnd_rdy   = 1'b0;
    assign ready = rand_en ? rnd_rdy : ready_man;

    uart_rx_fifo #(
        .TICKS_PER_BIT (T),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .data_out   (data_out),
        .valid      (valid),
        .ready      (ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
`ifdef UART_RX_PARITY_EN
        .parity_err (parity_err),
`endif
        .count      (count)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
        #2;
        rnd_rdy = 1'($urandom_range(0, 1));
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: records popped bytes and output pulses away from the active edge.
    logic [7:0] got_q[$];
    int   fe_cnt   = 0;
    int   ov_cnt   = 0;
    int   pe_cnt   = 0;
    int   rise_cyc = -1;
    logic valid_d  = 1'b0;

    always @(negedge clk) begin
        if (!reset) begin
            if (valid && ready) got_q.push_back(data_out);
            if (frame_err) fe_cnt++;
            if (overrun) ov_cnt++;
`ifdef UART_RX_PARITY_EN
            if (parity_err) pe_cnt++;
`endif
            if (frame_err || overrun) chk("pulse_exclusive", 32'(frame_err && overrun), 0);
            if (valid && !valid_d) rise_cyc = cyc;
        end
        valid_d = valid;
    end

    int got_rd = 0;

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        step(T);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic bad_par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^d) ^ bad_par);
`else
        if (bad_par) rx = 1'b1;
`endif
        send_bit(stop);
        rx = 1'b1;
    endtask

    task automatic drain();
        int guard = 0;
        ready_man = 1'b1;
        while (valid && guard < 4 * DEPTH) begin
            step();
            guard++;
        end
        ready_man = 1'b0;
        step();
        chk("drain_empty", 32'(valid), 0);
    endtask

    task automatic chk_pop(input string name, input logic [7:0] exp);
        if (got_rd < got_q.size()) begin
            chk(name, 32'(got_q[got_rd]), 32'(exp));
            got_rd++;
        end else begin
            chk(name, 32'hFFFF_FFFF, 32'(exp));
        end
    endtask

    typedef struct {
        logic [7:0] dat;
        logic       stop;
        int         exp_cnt;
        logic       exp_vld;
        logic [7:0] exp_head;
        int         exp_fe;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int c0;
        int fe0;
        int ov0;
        int pe0;
        logic [7:0] exp_q[$];
        int exp_fe;

        vecs[0] = '{8'hA5, 1'b1, 1, 1'b1, 8'hA5, 0};
        vecs[1] = '{8'h55, 1'b0, 0, 1'b0, 8'h00, 1};
        vecs[2] = '{8'h12, 1'b1, 1, 1'b1, 8'h12, 0};
        vecs[3] = '{8'h00, 1'b1, 1, 1'b1, 8'h00, 0};
        vecs[4] = '{8'hFF, 1'b1, 1, 1'b1, 8'hFF, 0};
        vecs[5] = '{8'h80, 1'b0, 0, 1'b0, 8'h00, 1};
        vecs[6] = '{8'h3C, 1'b1, 1, 1'b1, 8'h3C, 0};
        vecs[7] = '{8'h01, 1'b1, 1, 1'b1, 8'h01, 0};

        rx    = 1'b1;
        reset = 1'b1;
        step(3);
        chk("rst_data_out", 32'(data_out), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_frame_err", 32'(frame_err), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_count", 32'(count), 0);
        reset = 1'b0;
        step(10);

        // Single frame with exact write-to-valid latency.
        rise_cyc = -1;
        c0 = cyc;
        send_frame(8'hA5, 1'b1, 1'b0);
        step(2);
        chk("a5_latency", 32'(rise_cyc - c0), 32'(LAT));
        chk("a5_head", 32'(data_out), 32'hA5);
        chk("a5_count", 32'(count), 1);
        ready_man = 1'b1;
        step();
        ready_man = 1'b0;
        chk("a5_pop_valid", 32'(valid), 0);
        chk("a5_pop_count", 32'(count), 0);
        chk_pop("a5_pop_byte", 8'hA5);
        step(5);

        for (int i = 0; i < 8; i++) begin
            fe0 = fe_cnt;
            send_frame(vecs[i].dat, vecs[i].stop, 1'b0);
            step(2);
            chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_cnt));
            chk($sformatf("vec%0d_valid", i), 32'(valid), 32'(vecs[i].exp_vld));
            if (vecs[i].exp_vld) chk($sformatf("vec%0d_head", i), 32'(data_out), 32'(vecs[i].exp_head));
            chk($sformatf("vec%0d_frame_err", i), 32'(fe_cnt - fe0), 32'(vecs[i].exp_fe));
            drain();
            if (vecs[i].exp_vld) chk_pop($sformatf("vec%0d_pop", i), vecs[i].exp_head);
            step(5);
        end

        // Back-to-back frames, no idle gap.
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        send_frame(8'h3C, 1'b1, 1'b0);
        step(2);
        chk("b2b_count", 32'(count), 3);
        drain();
        chk_pop("b2b_pop0", 8'h00);
        chk_pop("b2b_pop1", 8'hFF);
        chk_pop("b2b_pop2", 8'h3C);
        step(5);

        // Short low glitch: false start, nothing reported.
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        rx = 1'b0;
        step(30);
        rx = 1'b1;
        step(2 * T);
        chk("glitch_count", 32'(count), 0);
        chk("glitch_valid", 32'(valid), 0);
        chk("glitch_pulses", 32'((fe_cnt - fe0) + (ov_cnt - ov0)), 0);

        // Overflow: fifth byte dropped with overrun.
        ov0 = ov_cnt;
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0);
        step(2);
        chk("ovf_count", 32'(count), 4);
        chk("ovf_overrun", 32'(ov_cnt - ov0), 1);
        drain();
        for (int i = 1; i <= 4; i++) chk_pop($sformatf("ovf_pop%0d", i), 8'(i));
        step(5);

        // Full FIFO with a pop in the write cycle: push accepted, no overrun.
        ov0 = ov_cnt;
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 1'b0);
        fork
            send_frame(8'h05, 1'b1, 1'b0);
            begin
                step(LAT - 1);
                ready_man = 1'b1;
                step();
                ready_man = 1'b0;
            end
        join
        step(2);
        chk("fullpop_overrun", 32'(ov_cnt - ov0), 0);
        chk("fullpop_count", 32'(count), 4);
        chk("fullpop_head", 32'(data_out), 32'h02);
        drain();
        for (int i = 1; i <= 5; i++) chk_pop($sformatf("fullpop_pop%0d", i), 8'(i));
        step(5);

        // Reset mid-DATA of 0x81 with a byte already buffered.
        send_frame(8'h3C, 1'b1, 1'b0);
        step(2);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        reset = 1'b1;
        step();
        chk("midrst_data_out", 32'(data_out), 0);
        chk("midrst_valid", 32'(valid), 0);
        chk("midrst_pulses", 32'({frame_err, overrun}), 0);
        chk("midrst_count", 32'(count), 0);
        rx = 1'b1;
        step();
        reset = 1'b0;
        step(2 * T);
        send_frame(8'h7E, 1'b1, 1'b0);
        step(2);
        chk("midrst_next_count", 32'(count), 1);
        chk("midrst_next_head", 32'(data_out), 32'h7E);
        drain();
        chk_pop("midrst_next_pop", 8'h7E);
        step(5);

`ifdef UART_RX_PARITY_EN
        pe0 = pe_cnt;
        send_frame(8'h07, 1'b1, 1'b1);
        step(2);
        chk("par_bad_pulse", 32'(pe_cnt - pe0), 1);
        chk("par_bad_count", 32'(count), 0);
        send_frame(8'h07, 1'b1, 1'b0);
        step(2);
        chk("par_good_count", 32'(count), 1);
        chk("par_good_head", 32'(data_out), 32'h07);
        drain();
        chk_pop("par_good_pop", 8'h07);
        step(5);
`endif

        // Randomized frames against a queue model of accepted bytes.
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        pe0 = pe_cnt;
        exp_fe = 0;
        rand_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            logic [7:0] d;
            logic       s;
            d = 8'($urandom);
            s = ($urandom_range(0, 7) != 0);
            send_frame(d, s, 1'b0);
            if (s) exp_q.push_back(d);
            else exp_fe++;
            step($urandom_range(1, 40));
        end
        step(4);
        rand_en = 1'b0;
        drain();
        chk("rnd_pop_total", 32'(got_q.size() - got_rd), 32'(exp_q.size()));
        foreach (exp_q[i]) chk_pop($sformatf("rnd_pop%0d", i), exp_q[i]);
        chk("rnd_frame_err", 32'(fe_cnt - fe0), 32'(exp_fe));
        chk("rnd_overrun", 32'(ov_cnt - ov0), 0);
        chk("rnd_parity_err", 32'(pe_cnt - pe0), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached, test incomplete");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
